// File: rtl/sha256_block_padder_if.sv
`default_nettype none
// ============================================================================
// sha256_block_padder_if : padded-block valid/ready bundle   (rev 1.0)
// ============================================================================
interface sha256_block_padder_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic [7:0]   blk_index;

    modport master (
        output blk_valid,
        output blk_data,
        output blk_last,
        output blk_index,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_data,
        input  blk_last,
        input  blk_index,
        output blk_ready
    );
endinterface
`default_nettype wire

// File: rtl/sha256_block_padder.sv
`default_nettype none
// ============================================================================
// sha256_block_padder : fetches a message and emits SHA-256 padded blocks (rev 1.0)
// ============================================================================
module sha256_block_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  wire                   clk,
    input  wire                   reset_n,
    input  wire                   start,
    input  wire  [15:0]           message_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    input  wire  [31:0]           mem_read_data,
    sha256_block_padder_if.master blk
);

    localparam int          TOTAL      = 16 * ((NUM_OF_WORDS + 3 + 15) / 16);
    localparam int          NUM_BLOCKS = TOTAL / 16;
    localparam logic [12:0] MSG_WORDS  = 13'(NUM_OF_WORDS);
    localparam logic [12:0] LEN_WORD   = 13'(TOTAL - 1);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);
    localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        OFFER  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [4:0]       step;
    logic [15:0]      base;
    logic [0:15][31:0] words;
    logic [3:0]       fill_slot;
    logic [12:0]      g_issue;
    logic [12:0]      g_fill;
    logic [31:0]      fill_word;

    assign mem_clk       = clk;
    assign mem_we        = 1'b0;
    assign blk.blk_data  = words;

    // Step 0 only issues the first address; step s writes slot s-1, so the
    // fill always takes 17 cycles regardless of how many slots are padding.
    assign fill_slot = step[3:0] - 4'd1;
    assign g_issue   = {1'b0, blk.blk_index, step[3:0]};
    assign g_fill    = {1'b0, blk.blk_index, fill_slot};

    // The upper half of the 64-bit length is always zero for legal lengths.
    always_comb begin
        fill_word = 32'h0000_0000;
        if (g_fill < MSG_WORDS)
            fill_word = mem_read_data;
        else if (g_fill == MSG_WORDS)
            fill_word = 32'h8000_0000;
        else if (g_fill == LEN_WORD)
            fill_word = BIT_LEN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        blk.blk_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (step == 5'd16)
                    state_next = OFFER;
            end
            OFFER: begin
                busy          = 1'b1;
                blk.blk_valid = 1'b1;
                if (blk.blk_ready)
                    state_next = blk.blk_last ? FINISH : FILL;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base          <= 16'h0000;
            step          <= 5'd0;
            mem_addr      <= 16'h0000;
            words         <= '0;
            blk.blk_index <= 8'd0;
            blk.blk_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base          <= message_addr;
                        mem_addr      <= message_addr;
                        step          <= 5'd0;
                        blk.blk_index <= 8'd0;
                    end
                end
                FILL: begin
                    step <= step + 5'd1;
                    if (step != 5'd0)
                        words[fill_slot] <= fill_word;
                    if (!step[4] && (g_issue < MSG_WORDS))
                        mem_addr <= base + {3'b000, g_issue};
                    if (step == 5'd16)
                        blk.blk_last <= (blk.blk_index == LAST_BLK);
                end
                OFFER: begin
                    if (blk.blk_ready) begin
                        step         <= 5'd0;
                        blk.blk_last <= 1'b0;
                        if (!blk.blk_last)
                            blk.blk_index <= blk.blk_index + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_padder.sv
`default_nettype none
// ============================================================================
// tb_sha256_block_padder : scoreboard bench for three message lengths (rev 1.0)
// ============================================================================
module tb_sha256_block_padder;

    localparam int NINST = 3;

    typedef struct {
        int           inst;
        logic [511:0] data;
        logic         last;
        logic [7:0]   index;
    } blk_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NINST-1:0]        start_v = '0;
    logic [NINST-1:0][15:0]  addr_v  = '0;
    logic [NINST-1:0]        ready_v = '0;
    logic [NINST-1:0]        busy_v, done_v, valid_v, last_v, we_v, mclk_v;
    logic [NINST-1:0][15:0]  maddr_v;
    logic [NINST-1:0][7:0]   index_v;
    logic [NINST-1:0][511:0] data_v;

    int          compared   = 0;
    int          mismatched = 0;
    blk_t        exp_q[$];
    logic [15:0] addr_log[$];
    logic [15:0] cur_base [NINST];
    int          done_cnt [NINST];
    int          max_off  [NINST];
    blk_t        mon_e;
    logic [15:0] mon_off;

    function automatic int nw(int k);
        return (k == 0) ? 20 : ((k == 1) ? 13 : 14);
    endfunction

    for (genvar k = 0; k < NINST; k++) begin : g_dut
        localparam int NWK = (k == 0) ? 20 : ((k == 1) ? 13 : 14);
        sha256_block_padder_if bus ();
        logic [15:0] maddr;
        logic [31:0] rdata;
        logic        mclk;
        logic        mwe;

        assign rdata         = {16'h0000, maddr} + 32'd1;
        assign bus.blk_ready = ready_v[k];

        sha256_block_padder #(.NUM_OF_WORDS(NWK)) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (start_v[k]),
            .message_addr  (addr_v[k]),
            .busy          (busy_v[k]),
            .done          (done_v[k]),
            .mem_clk       (mclk),
            .mem_we        (mwe),
            .mem_addr      (maddr),
            .mem_read_data (rdata),
            .blk           (bus)
        );

        assign valid_v[k] = bus.blk_valid;
        assign last_v[k]  = bus.blk_last;
        assign index_v[k] = bus.blk_index;
        assign data_v[k]  = bus.blk_data;
        assign maddr_v[k] = maddr;
        assign we_v[k]    = mwe;
        assign mclk_v[k]  = mclk;
    end

    // Memory holds (address + 1) at every address.
    function automatic logic [31:0] exp_word(int n, logic [15:0] base, int g);
        int          total;
        logic [15:0] a;
        total = 16 * ((n + 18) / 16);
        if (g < n) begin
            a = base + 16'(g);
            return {16'h0000, a} + 32'd1;
        end
        if (g == n)         return 32'h8000_0000;
        if (g == total - 1) return 32'(n * 32);
        return 32'h0000_0000;
    endfunction

    task automatic push_message(int k, logic [15:0] base);
        int   n;
        int   nb;
        blk_t e;
        n  = nw(k);
        nb = (n + 18) / 16;
        for (int b = 0; b < nb; b++) begin
            e.inst  = k;
            e.last  = (b == nb - 1);
            e.index = 8'(b);
            for (int w = 0; w < 16; w++)
                e.data[511 - 32*w -: 32] = exp_word(n, base, 16*b + w);
            exp_q.push_back(e);
        end
    endtask

    // Returns 1 ns after the edge that accepts start.
    task automatic pulse_start(int k, logic [15:0] base);
        @(posedge clk); #1;
        start_v[k]  = 1'b1;
        addr_v[k]   = base;
        cur_base[k] = base;
        @(posedge clk); #1;
        start_v[k]  = 1'b0;
        addr_v[k]   = 16'h5A5A;
    endtask

    task automatic wait_valid(int k, int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (valid_v[k]) return;
        end
        cycles = -1;
    endtask

    task automatic wait_done(int k, int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_v[k]) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NINST; k++) begin
            if (done_v[k]) done_cnt[k]++;
            if (busy_v[k]) begin
                mon_off = maddr_v[k] - cur_base[k];
                compared++;
                if (int'(mon_off) >= nw(k)) begin
                    mismatched++;
                    $display("FAIL addr_range inst%0d: mem_addr=%h, required base %h + 0..%0d", k, maddr_v[k], cur_base[k], nw(k) - 1);
                end else if (int'(mon_off) > max_off[k]) begin
                    max_off[k] = int'(mon_off);
                end
            end
            if (valid_v[k] && ready_v[k]) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_block inst%0d: got index=%0d, required no block", k, index_v[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.inst != k || data_v[k] !== mon_e.data || last_v[k] !== mon_e.last || index_v[k] !== mon_e.index) begin
                        mismatched++;
                        $display("FAIL block inst%0d: got idx=%0d last=%0b data=%h, required inst%0d idx=%0d last=%0b data=%h",
                                 k, index_v[k], last_v[k], data_v[k], mon_e.inst, mon_e.index, mon_e.last, mon_e.data);
                    end
                end
            end
        end
        if (busy_v[0] && (addr_log.size() == 0 || addr_log[$] != maddr_v[0]))
            addr_log.push_back(maddr_v[0]);
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NINST; k++) begin
            compared++;
            if ({busy_v[k], done_v[k], valid_v[k], last_v[k], we_v[k], index_v[k], maddr_v[k]} !== 29'd0) begin
                mismatched++;
                $display("FAIL reset_ctrl inst%0d: busy=%b done=%b valid=%b last=%b we=%b idx=%h addr=%h, required all 0",
                         k, busy_v[k], done_v[k], valid_v[k], last_v[k], we_v[k], index_v[k], maddr_v[k]);
            end
            compared++;
            if (data_v[k] !== 512'd0) begin
                mismatched++;
                $display("FAIL reset_data inst%0d: got %h, required 0", k, data_v[k]);
            end
        end
        compared++;
        if (mclk_v[0] !== clk) begin
            mismatched++;
            $display("FAIL mem_clk: got %b, required %b", mclk_v[0], clk);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_n20_basic();
        int cyc;
        bit seen;
        int d0;
        d0 = done_cnt[0];
        ready_v[0] = 1'b1;
        push_message(0, 16'h0000);
        pulse_start(0, 16'h0000);
        compared++;
        if (busy_v[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL n20_busy: got %b, required 1", busy_v[0]);
        end
        wait_valid(0, 40, cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++;
            $display("FAIL n20_latency: got %0d cycles, required 17", cyc);
        end
        wait_done(0, 100, seen);
        compared++;
        if (!seen || busy_v[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL n20_done: seen=%b busy=%b, required seen=1 busy=0", seen, busy_v[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (done_cnt[0] - d0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL n20_complete: done pulses=%0d pending=%0d, required 1 and 0", done_cnt[0] - d0, exp_q.size());
        end
    endtask

    task automatic test_short(int k, logic [15:0] base, int want_max);
        int cyc;
        bit seen;
        int d0;
        d0 = done_cnt[k];
        max_off[k] = 0;
        ready_v[k] = 1'b1;
        push_message(k, base);
        pulse_start(k, base);
        wait_valid(k, 40, cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++;
            $display("FAIL short%0d_latency: got %0d cycles, required 17", nw(k), cyc);
        end
        wait_done(k, 100, seen);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (!seen || done_cnt[k] - d0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL short%0d_complete: seen=%b done pulses=%0d pending=%0d, required 1/1/0", nw(k), seen, done_cnt[k] - d0, exp_q.size());
        end
        compared++;
        if (max_off[k] != want_max) begin
            mismatched++;
            $display("FAIL short%0d_reads: furthest offset=%0d, required %0d", nw(k), max_off[k], want_max);
        end
    endtask

    task automatic test_stall();
        int   cyc;
        bit   seen;
        blk_t e;
        ready_v[0] = 1'b0;
        push_message(0, 16'h0100);
        e = exp_q[0];
        pulse_start(0, 16'h0100);
        wait_valid(0, 40, cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++;
            $display("FAIL stall_latency0: got %0d cycles, required 17", cyc);
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            compared++;
            if (valid_v[0] !== 1'b1 || data_v[0] !== e.data || index_v[0] !== e.index || last_v[0] !== e.last) begin
                mismatched++;
                $display("FAIL stall_hold cycle %0d: valid=%b idx=%0d last=%b, required valid=1 idx=%0d last=%b", i, valid_v[0], index_v[0], last_v[0], e.index, e.last);
            end
        end
        ready_v[0] = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (valid_v[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_drop: valid=%b after transfer, required 0", valid_v[0]);
        end
        wait_valid(0, 40, cyc);
        compared++;
        if (cyc != 17) begin
            mismatched++;
            $display("FAIL stall_latency1: got %0d cycles, required 17", cyc);
        end
        wait_done(0, 100, seen);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (!seen || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL stall_complete: seen=%b pending=%0d, required 1 and 0", seen, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        int d0;
        ready_v[0] = 1'b1;
        push_message(0, 16'h0000);
        pulse_start(0, 16'h0000);
        wait_valid(0, 40, cyc);
        repeat (6) @(posedge clk);
        #1;
        d0 = done_cnt[0];
        reset_n = 1'b0;
        #1;
        compared++;
        if ({busy_v[0], done_v[0], valid_v[0], last_v[0], index_v[0], maddr_v[0]} !== 28'd0 || data_v[0] !== 512'd0) begin
            mismatched++;
            $display("FAIL midreset_outputs: busy=%b valid=%b last=%b idx=%h addr=%h, required all 0",
                     busy_v[0], valid_v[0], last_v[0], index_v[0], maddr_v[0]);
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if (done_cnt[0] != d0 || busy_v[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_nodone: done pulses=%0d busy=%b, required 0 and 0", done_cnt[0] - d0, busy_v[0]);
        end
        push_message(0, 16'h0000);
        pulse_start(0, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        addr_v[0]  = 16'h1234;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, 100, seen);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (!seen || done_cnt[0] - d0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL midreset_restart: seen=%b done pulses=%0d pending=%0d, required 1/1/0", seen, done_cnt[0] - d0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit          seen;
        logic [15:0] want;
        ready_v[0] = 1'b1;
        addr_log.delete();
        push_message(0, 16'hFFFE);
        pulse_start(0, 16'hFFFE);
        wait_done(0, 100, seen);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (!seen || addr_log.size() != 20 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL wrap_run: seen=%b addresses=%0d pending=%0d, required 1/20/0", seen, addr_log.size(), exp_q.size());
        end
        for (int i = 0; i < 20 && i < addr_log.size(); i++) begin
            want = 16'hFFFE + 16'(i);
            compared++;
            if (addr_log[i] !== want) begin
                mismatched++;
                $display("FAIL wrap_addr[%0d]: got %h, required %h", i, addr_log[i], want);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int gap;
        int d0;
        d0 = done_cnt[1];
        ready_v[1] = 1'b1;
        push_message(1, 16'h0040);
        push_message(1, 16'h0040);
        @(posedge clk); #1;
        start_v[1]  = 1'b1;
        addr_v[1]   = 16'h0040;
        cur_base[1] = 16'h0040;
        wait_done(1, 100, seen);
        gap = -1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (busy_v[1]) begin
                gap = i;
                break;
            end
        end
        start_v[1] = 1'b0;
        compared++;
        if (!seen || gap != 2) begin
            mismatched++;
            $display("FAIL b2b_restart: seen=%b busy again after %0d cycles, required 1 and 2", seen, gap);
        end
        wait_done(1, 100, seen);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (!seen || done_cnt[1] - d0 != 2 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_complete: seen=%b done pulses=%0d pending=%0d, required 1/2/0", seen, done_cnt[1] - d0, exp_q.size());
        end
    endtask

    initial begin
        for (int k = 0; k < NINST; k++) begin
            done_cnt[k] = 0;
            max_off[k]  = 0;
            cur_base[k] = 16'h0000;
        end
        test_reset();
        test_n20_basic();
        test_short(1, 16'h0200, 12);
        test_short(2, 16'h0300, 13);
        test_stall();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sha256_block_padder.md
Name: sha256_block_padder

Overview:
Upstream stage of the SHA-256 core. Fetches a NUM_OF_WORDS-word message from word-addressed memory and applies SHA-256 padding: a 0x80000000 marker word, zero fill, and a 64-bit big-endian bit length. It emits the result as a sequence of 512-bit blocks over a valid/ready handshake. The compression stage consumes one block per transfer and needs no knowledge of message length or padding.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4000.

Ports:
clk  in  1  clock; also drives mem_clk
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a message; sampled only in IDLE
message_addr  in  16  word address of message word 0; latched when start is accepted
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last block transfers
mem_clk  out  1  equals clk
mem_we  out  1  tied 0; this block only reads
mem_addr  out  16  registered read address
mem_read_data  in  32  read data; valid one cycle after mem_addr
blk_valid  out  1  blk_data holds a complete padded block
blk_ready  in  1  consumer accepts the block
blk_data  out  512  block; word 0 in [511:480], word 15 in [31:0]
blk_last  out  1  qualifies blk_valid: final block of the message
blk_index  out  8  block number, 0-based

Behaviour:
- Block count: TOTAL = 16*ceil((N+3)/16) words, NUM_BLOCKS = TOTAL/16. For N=20: TOTAL=32, NUM_BLOCKS=2.
- Value of global word g (0..TOTAL-1):
  - g<N: mem[message_addr+g]
  - g==N: 32'h80000000
  - g==TOTAL-2: upper 32 bits of N*32 (0 for all legal N)
  - g==TOTAL-1: N*32
  - otherwise: 0
- Reset: state=IDLE; busy, done, blk_valid, blk_last = 0; mem_addr, blk_data, blk_index = 0.
- States: IDLE, FILL, OFFER, FINISH.
  - IDLE: start=1 latches message_addr, sets busy=1, clears block counter, goes to FILL.
  - FILL: fills slots 0..15 in order, one slot per cycle.
    - Memory slots: mem_addr is issued one cycle ahead, so the 32-bit read data lands in its slot on the following edge.
    - Padding slots are written directly; no memory access is issued for them.
    - mem_addr never advances past message_addr+N-1.
    - After slot 15 is written, go to OFFER.
  - Fill latency is fixed: blk_valid rises exactly 17 cycles after the edge that accepted start, or after the edge of the previous transfer. This holds regardless of how many slots are padding.
  - OFFER: blk_valid=1. blk_data, blk_last and blk_index are held stable until a transfer occurs.
    - Transfer = blk_valid & blk_ready on a rising edge.
    - On transfer, blk_valid drops on that edge.
    - Not last block: increment blk_index, go to FILL.
    - Last block: go to FINISH.
    - blk_ready held low stalls indefinitely with no loss of data.
  - FINISH: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored; message_addr changes after acceptance have no effect.
- blk_ready while blk_valid=0 is ignored.
- Address arithmetic is 16-bit and wraps: message_addr=16'hFFFF reads FFFF, 0000, 0001, ...
- reset_n low mid-operation, including during OFFER: all state returns to reset values immediately; the partial block is discarded and no done pulse is issued.
- start may be accepted in the IDLE cycle directly after FINISH.

Test Plan:
- N=20, message_addr=0x0000, mem[i]=i+1, blk_ready=1 → block0 = words 1..16 with blk_last=0, blk_index=0. Block1 = 17,18,19,20, 0x80000000, 9 zeros, 0, 0x00000280, with blk_last=1. Single done pulse; blk_valid first rises 17 cycles after start.
- N=13 → exactly one block: words 0..12 from memory, word13=0x80000000, word14=0, word15=0x000001A0, blk_last=1.
- N=14 → two blocks: block0 word14=0x80000000, word15=0. Block1 = 14 zeros, 0, 0x000001C0. No memory reads beyond message_addr+13.
- Stall: hold blk_ready=0 for 50 cycles in OFFER with N=20 → blk_valid, blk_data and blk_index stay constant. After blk_ready=1, exactly one transfer occurs and the next block appears 17 cycles later.
- Reset and ignored start: pulse reset_n low during block1 FILL → outputs return to reset values at once, no done. A fresh start then re-emits block0 correctly. start asserted while busy leaves the output stream unchanged.
- Wrap: message_addr=16'hFFFE, N=20 → mem_addr sequence FFFE, FFFF, 0000, ..., 0011; data is correct.
